// File: rtl/kd_tree_node_loader.sv
// Streams NUM_NODES node words (median | dimension index) from upstream into
// the internal kd-tree node registers, one one-hot write pulse per accepted word.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting node words, in_ready high
// DONE  | final node written this cycle, done pulse
// ERR   | bad index or early last seen; error held until next start
module kd_tree_node_loader #(
    parameter int DATA_WIDTH    = 55,
    parameter int STORAGE_WIDTH = 22,
    parameter int NUM_NODES     = 31,
    parameter int NUM_DIMS      = 5,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [STORAGE_WIDTH-1:0] in_data,
    input  logic                     in_last,
    output logic [NUM_NODES-1:0]     node_wen,
    output logic [STORAGE_WIDTH-1:0] node_wdata,
    output logic [ADDR_WIDTH-1:0]    node_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    // Index field width equals one patch component width.
    localparam int IDX_W = DATA_WIDTH / NUM_DIMS;
    localparam logic [IDX_W-1:0]      DIMS_LIM  = IDX_W'(NUM_DIMS);
    localparam logic [ADDR_WIDTH-1:0] LAST_NODE = ADDR_WIDTH'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                   state, state_d;
    logic [ADDR_WIDTH-1:0]    cnt, cnt_d;
    logic [NUM_NODES-1:0]     wen_d;
    logic [STORAGE_WIDTH-1:0] wdata_d;
    logic [ADDR_WIDTH-1:0]    addr_d;
    logic                     accept;
    logic                     bad_idx;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);

    assign accept  = in_valid & in_ready;
    assign bad_idx = (in_data[IDX_W-1:0] >= DIMS_LIM);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            node_wen   <= '0;
            node_wdata <= '0;
            node_addr  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            node_wen   <= wen_d;
            node_wdata <= wdata_d;
            node_addr  <= addr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wen_d   = '0;
        wdata_d = node_wdata;
        addr_d  = node_addr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (bad_idx) begin
                        state_d = S_ERR;
                    end else begin
                        for (int i = 0; i < NUM_NODES; i++) begin
                            wen_d[i] = (cnt == ADDR_WIDTH'(i));
                        end
                        wdata_d = in_data;
                        addr_d  = cnt;
                        // Counter parks on the last node rather than wrapping.
                        if (cnt == LAST_NODE) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt + 1'b1;
                            if (in_last) begin
                                state_d = S_ERR;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_kd_tree_node_loader.sv
// Scoreboard bench for kd_tree_node_loader: the driver queues each expected
// node write; a negedge monitor pops and checks every write/done it sees.
module tb_kd_tree_node_loader;

    localparam int SW = 22;
    localparam int NN = 31;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_data;
    logic          in_last;
    logic [NN-1:0] node_wen;
    logic [SW-1:0] node_wdata;
    logic [AW-1:0] node_addr;
    logic          busy;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            addr;
        logic [SW-1:0] data;
        logic          is_done;
    } exp_t;

    exp_t exp_q[$];

    kd_tree_node_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .node_wen   (node_wen),
        .node_wdata (node_wdata),
        .node_addr  (node_addr),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [SW-1:0] word(input int k);
        logic [10:0] med;
        logic [10:0] idx;
        med = 11'(k + 1);
        idx = 11'(k % 5);
        return {med, idx};
    endfunction

    // Monitor: every write pulse or done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (node_wen != '0 || done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: wen=%0h addr=%0d done=%0b", node_wen, node_addr, done);
            end else begin
                exp_t e;
                logic [NN-1:0] oh;
                e  = exp_q.pop_front();
                oh = NN'(1) << e.addr;
                check("wen", 64'(node_wen), 64'(oh));
                check("addr", 64'(node_addr), 64'(e.addr));
                check("wdata", 64'(node_wdata), 64'(e.data));
                check("done", 64'(done), 64'(e.is_done));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive word k for one cycle (state must be LOAD), then idle for gap cycles.
    task automatic send(input int k, input logic last, input int gap, input logic expect_wr);
        exp_t e;
        in_valid = 1'b1;
        in_data  = word(k);
        in_last  = last;
        if (expect_wr) begin
            e.addr    = k;
            e.data    = word(k);
            e.is_done = (k == NN - 1);
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic full_load(input int gap);
        do_start();
        for (int k = 0; k < NN; k++) send(k, k == NN - 1, (k == NN - 1) ? 0 : gap, 1'b1);
    endtask

    task automatic drain_check(input string name);
        tick();
        tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = word(0);
        in_last  = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_outputs", 64'({in_ready, node_wen, node_wdata, node_addr, busy, done, error}), 64'd0);
        #1;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();

        // Full back-to-back load; busy falls as done rises.
        do_start();
        for (int k = 0; k < NN; k++) begin
            if (k == NN - 1) begin
                send(k, 1'b1, 0, 1'b1);
            end else begin
                send(k, 1'b0, 0, 1'b1);
            end
        end
        @(negedge clk);
        check("done_final", 64'(done), 64'd1);
        check("busy_final", 64'(busy), 64'd0);
        #1;
        // Surplus word after the last node must be ignored.
        in_valid = 1'b1;
        in_data  = word(3);
        tick();
        tick();
        in_valid = 1'b0;
        drain_check("full_load_drain");

        // Gapped valid 1,0,0,1,...
        full_load(2);
        drain_check("gap_load_drain");

        // Bad index on the third word.
        do_start();
        send(0, 1'b0, 0, 1'b1);
        send(1, 1'b0, 0, 1'b1);
        in_valid = 1'b1;
        in_data  = 22'b00000000001_00000000101;
        tick();
        @(negedge clk);
        check("bad_idx_error", 64'(error), 64'd1);
        check("bad_idx_ready", 64'(in_ready), 64'd0);
        #1;
        in_data = word(2);
        tick();
        tick();
        in_valid = 1'b0;
        check("bad_idx_still_err", 64'(error), 64'd1);
        do_start();
        check("err_cleared", 64'(error), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        for (int k = 0; k < NN; k++) send(k, k == NN - 1, 0, 1'b1);
        drain_check("bad_idx_drain");

        // Early last on word 9.
        do_start();
        for (int k = 0; k < 10; k++) send(k, k == 9, 0, 1'b1);
        @(negedge clk);
        check("early_last_error", 64'(error), 64'd1);
        #1;
        send(10, 1'b0, 1, 1'b0);
        check("early_last_no_done", 64'(done), 64'd0);
        drain_check("early_last_drain");

        // Reset coinciding with acceptance of word 12.
        do_start();
        for (int k = 0; k < 12; k++) send(k, 1'b0, 0, 1'b1);
        rst_n = 1'b1;
        send(12, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", 64'({in_ready, node_wen, node_wdata, node_addr, busy, done, error}), 64'd0);
        #1;
        full_load(0);
        drain_check("midrst_drain");

        // Start with valid in IDLE, then a second start inside LOAD.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = word(0);
        @(negedge clk);
        check("coincide_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < NN; k++) begin
            start = (k == 4);
            send(k, k == NN - 1, 0, 1'b1);
        end
        start = 1'b0;
        drain_check("coincide_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kd_tree_node_loader.md
KD_TREE_NODE_LOADER -- requirements
Module: kd_tree_node_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 55, the patch width (NUM_DIMS components of 11 bits each).
REQ-002 SHALL have parameter STORAGE_WIDTH, default 22, the node word width: [21:11] = median, [10:0] = dimension index.
REQ-003 SHALL have parameter NUM_NODES, default 31, the number of internal nodes programmed per load.
REQ-004 SHALL have parameter NUM_DIMS, default 5, the number of patch components.
REQ-005 SHALL have parameter ADDR_WIDTH, default 5, the node address width, with NUM_NODES <= 2^ADDR_WIDTH.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous, active-high reset (asserted = 1, despite the name).
REQ-008 SHALL have port start  input  1  a one-cycle request that begins a load.
REQ-009 SHALL have port in_valid  input  1  the upstream node word is valid.
REQ-010 SHALL have port in_ready  output  1  the loader accepts a word this cycle.
REQ-011 SHALL have port in_data  input  STORAGE_WIDTH  the upstream node word.
REQ-012 SHALL have port in_last  input  1  marks the final word of the upstream stream.
REQ-013 SHALL have port node_wen  output  NUM_NODES  the one-hot write enable to internal nodes.
REQ-014 SHALL have port node_wdata  output  STORAGE_WIDTH  the shared write data to all internal nodes.
REQ-015 SHALL have port node_addr  output  ADDR_WIDTH  the index of the node being written.
REQ-016 SHALL have port busy  output  1  high while in LOAD.
REQ-017 SHALL have port done  output  1  a one-cycle pulse on successful completion.
REQ-018 SHALL have port error  output  1  a sticky flag that is high in ERR.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, DONE and ERR.
REQ-020 SHALL make these transitions:
- IDLE->LOAD on start.
- LOAD->DONE when word NUM_NODES-1 is accepted.
- DONE->IDLE after one cycle.
- ERR->LOAD on start.
REQ-021 SHALL drive in_ready = 1 only in LOAD; it SHALL be registered-state-derived and have no combinational path from in_valid.
REQ-022 SHALL treat a word as accepted when in_valid & in_ready, at one word per cycle maximum.
REQ-023 For a word accepted at cycle t with counter k, SHALL in cycle t+1 only:
- drive node_wen[k] = 1, with all other bits 0;
- drive node_wdata = in_data;
- drive node_addr = k.
REQ-024 SHALL hold node_wen at all zeros in every cycle without a pending write; node_wdata and node_addr SHALL hold their last value.
REQ-025 SHALL increment the node counter by 1 per accepted word, with no wrap: the counter SHALL be cleared on start and on reset.
REQ-026 SHALL treat an accepted word with index field >= NUM_DIMS as an error: no write (node_wen stays 0), and the next state SHALL be ERR.
REQ-027 SHALL treat in_last on an accepted word with counter < NUM_NODES-1 as an error: that word SHALL be written, then the next state SHALL be ERR.
REQ-028 SHALL accept word NUM_NODES-1 without in_last normally; surplus upstream words SHALL be left unconsumed (in_ready = 0).
REQ-029 SHALL assert done for exactly the one cycle in DONE, coincident with the final node_wen pulse.
REQ-030 SHALL keep error high in ERR and clear it on the start that leaves ERR.
REQ-031 SHALL ignore start in LOAD and DONE.
REQ-032 SHALL ignore in_valid in IDLE, DONE and ERR.
REQ-033 When start and in_valid coincide in IDLE, SHALL accept no word that cycle; the first acceptance SHALL be in the next cycle at the earliest.
REQ-034 SHALL have no other side channels; patch traffic (DATA_WIDTH) is not handled by this block.

Reset
REQ-035 When rst_n = 1 at a clock edge, SHALL set state = IDLE, counter = 0, in_ready = 0, node_wen = 0, node_wdata = 0, node_addr = 0, busy = 0, done = 0, error = 0.
REQ-036 When rst_n is asserted mid-LOAD, SHALL suppress any node_wen pulse that would have issued in the following cycle.
REQ-037 SHALL keep start ignored while rst_n is high.

Verification
REQ-038 Full load: start, then 31 back-to-back words with word k = {11'd(k+1), 11'd(k%5)} and in_last on k=30 -> node_wen = 1<<k and node_wdata = word k, one cycle after each acceptance; done high for the single cycle after word 30; busy falls in the same cycle.
REQ-039 Backpressure/gaps: in_valid toggled 1,0,0,1,... -> exactly one node_wen pulse per accepted word; node_addr strictly increasing 0..30; no pulses in idle cycles.
REQ-040 Bad index: third word = 22'b00000000001_00000000101 (index 5) -> node_wen[2] never asserted; error = 1 from the next cycle; in_ready = 0; a later start clears error and restarts at node 0.
REQ-041 Early last: in_last on word 9 -> node_wen[9] pulses; then error = 1, done never asserts, and node_wen[10] is never asserted.
REQ-042 Reset mid-load: rst_n = 1 in the same cycle as the acceptance of word 12 -> no node_wen pulse follows; all outputs are 0 next cycle; a subsequent start writes from node_wen[0].
REQ-043 Start/valid coincidence in IDLE, and start during LOAD -> no acceptance in the start cycle, and the counter is not reset by the second start.
